// File: rtl/dcache_axi_responder.sv
// Data-cache side responder: turns single-word cache requests into
// single-beat AXI3 reads/writes, one transaction outstanding at a time.
// Ports: clk/reset, data_cache_* request/response, AXI AR/R/AW/W/B
// channels, and a sticky bus_err flag for any non-OKAY response.
module dcache_axi_responder #(
  parameter logic [3:0] AXI_ID   = 4'd1,
  parameter bit         ADDR_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_cache_req,
  input  logic [3:0]  data_cache_wen,
  input  logic [31:0] data_cache_addr,
  input  logic [31:0] data_cache_wdata,
  output logic [31:0] data_cache_rdata,
  output logic        data_cache_dok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AWW,
    B,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] addr_q;
  logic [3:0]  wen_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        arvalid_q;
  logic        awvalid_q;
  logic        wvalid_q;
  logic        err_q;
  logic [31:0] mapped_addr;
  logic        aw_done;
  logic        w_done;

  // IDs and low address bits are not needed: one transaction in flight.
  logic unused_ok;
  assign unused_ok = ^{rid, bid, data_cache_addr[1:0]};

  // kseg0/kseg1 fold onto physical space by clearing the top 3 bits.
  always_comb begin
    mapped_addr = {data_cache_addr[31:2], 2'b00};
    if (ADDR_MAP &&
        (data_cache_addr[31:29] == 3'b100 ||
         data_cache_addr[31:29] == 3'b101))
      mapped_addr[31:29] = 3'b000;
  end

  // A channel is done once its valid has dropped or it handshakes now.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q || wready;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (data_cache_req)
          state_nxt = (data_cache_wen != 4'd0) ? AWW : AR;
      AR:
        if (arready) state_nxt = R;
      R:
        if (rvalid && rlast) state_nxt = DONE;
      AWW:
        if (aw_done && w_done) state_nxt = B;
      B:
        if (bvalid) state_nxt = DONE;
      DONE:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wen_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      arvalid_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_cache_req) begin
            addr_q  <= mapped_addr;
            wen_q   <= data_cache_wen;
            wdata_q <= data_cache_wdata;
            if (data_cache_wen != 4'd0) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              arvalid_q <= 1'b1;
            end
          end
        end
        AR:
          if (arready) arvalid_q <= 1'b0;
        R: begin
          if (rvalid && rlast) begin
            rdata_q <= rdata;
            err_q   <= err_q | (rresp != 2'b00);
          end
        end
        AWW: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
        end
        B:
          if (bvalid) err_q <= err_q | (bresp != 2'b00);
        default: ;
      endcase
    end
  end

  assign data_cache_rdata = rdata_q;
  assign data_cache_dok   = (state == DONE);
  assign bus_err          = err_q;

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = 4'd0;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign arvalid = arvalid_q;
  assign rready  = (state == R);

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = 4'd0;
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign awvalid = awvalid_q;

  assign wid     = AXI_ID;
  assign wdata   = wdata_q;
  assign wstrb   = wen_q;
  assign wlast   = wvalid_q;
  assign wvalid  = wvalid_q;

  assign bready  = (state == B);

endmodule

// File: tb/tb_dcache_axi_responder.sv
// Directed bench for dcache_axi_responder: reads, waited reads, split
// write handshakes, back-to-back requests, error responses, mid-R reset.
module tb_dcache_axi_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] cwdata;
  logic [31:0] crdata;
  logic        dok;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        bus_err;

  int tests  = 0;
  int failed = 0;
  int ar_hs  = 0;
  int aw_hs  = 0;
  int base;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && arvalid && arready) ar_hs <= ar_hs + 1;
    if (!reset && awvalid && awready) aw_hs <= aw_hs + 1;
  end

  dcache_axi_responder dut (
    .clk(clk), .reset(reset),
    .data_cache_req(req), .data_cache_wen(wen),
    .data_cache_addr(addr), .data_cache_wdata(cwdata),
    .data_cache_rdata(crdata), .data_cache_dok(dok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .bus_err(bus_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 0; wen = 0; addr = 0; cwdata = 0;
    arready = 0; rid = 4'd1; rdata = 0; rresp = 0;
    rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;
    tick();
    tick();
    check("rst_arvalid", {31'd0, arvalid}, 0);
    check("rst_awvalid", {31'd0, awvalid}, 0);
    check("rst_wvalid", {31'd0, wvalid}, 0);
    check("rst_rready", {31'd0, rready}, 0);
    check("rst_bready", {31'd0, bready}, 0);
    check("rst_dok", {31'd0, dok}, 0);
    check("rst_buserr", {31'd0, bus_err}, 0);
    check("rst_rdata", crdata, 0);
    check("rst_araddr", araddr, 0);
    reset = 1'b0;
    tick();

    // 1: zero-wait read
    req = 1; wen = 0; addr = 32'h8000_1004;
    arready = 1; rvalid = 1; rlast = 1; rdata = 32'hDEAD_BEEF;
    tick();
    check("t1_arvalid", {31'd0, arvalid}, 1);
    check("t1_araddr", araddr, 32'h0000_1004);
    check("t1_arfix", {17'd0, arid, arlen, arsize, arburst},
          {17'd0, 4'd1, 4'd0, 3'b010, 2'b01});
    tick();
    check("t1_rready", {31'd0, rready}, 1);
    check("t1_ardrop", {31'd0, arvalid}, 0);
    tick();
    check("t1_dok", {31'd0, dok}, 1);
    check("t1_rdata", crdata, 32'hDEAD_BEEF);
    check("t1_buserr", {31'd0, bus_err}, 0);
    req = 0; arready = 0; rvalid = 0; rlast = 0;
    tick();
    check("t1_dok_off", {31'd0, dok}, 0);

    // 2: read with arready and rvalid delays
    base = ar_hs;
    req = 1; addr = 32'h0000_2000;
    tick();
    check("t2_arv1", {31'd0, arvalid}, 1);
    tick();
    check("t2_arv2", {31'd0, arvalid}, 1);
    check("t2_araddr", araddr, 32'h0000_2000);
    tick();
    check("t2_arv3", {31'd0, arvalid}, 1);
    arready = 1;
    tick();
    arready = 0;
    check("t2_ardrop", {31'd0, arvalid}, 0);
    check("t2_rready", {31'd0, rready}, 1);
    tick();
    tick();
    check("t2_nodok", {31'd0, dok}, 0);
    rvalid = 1; rlast = 1; rdata = 32'hCAFE_F00D;
    tick();
    check("t2_dok", {31'd0, dok}, 1);
    check("t2_rdata", crdata, 32'hCAFE_F00D);
    check("t2_arhs", ar_hs - base, 1);
    req = 0; rvalid = 0; rlast = 0;
    tick();
    check("t2_dok_off", {31'd0, dok}, 0);

    // 3: write with split AW/W handshakes
    req = 1; wen = 4'b0011; addr = 32'hBFC0_0008; cwdata = 32'h1234_5678;
    tick();
    check("t3_awvalid", {31'd0, awvalid}, 1);
    check("t3_wvalid", {31'd0, wvalid}, 1);
    check("t3_awaddr", awaddr, 32'h1FC0_0008);
    check("t3_wstrb", {28'd0, wstrb}, 4'b0011);
    check("t3_wlast", {31'd0, wlast}, 1);
    check("t3_wdata", wdata, 32'h1234_5678);
    check("t3_awfix", {17'd0, awid, awlen, awsize, awburst},
          {17'd0, 4'd1, 4'd0, 3'b010, 2'b01});
    awready = 1;
    tick();
    awready = 0;
    check("t3_awdrop", {31'd0, awvalid}, 0);
    check("t3_wheld", {31'd0, wvalid}, 1);
    tick();
    check("t3_wheld2", {31'd0, wvalid}, 1);
    check("t3_nobready", {31'd0, bready}, 0);
    wready = 1;
    tick();
    wready = 0;
    check("t3_wdrop", {31'd0, wvalid}, 0);
    check("t3_bready", {31'd0, bready}, 1);
    bvalid = 1; bresp = 0;
    tick();
    check("t3_dok", {31'd0, dok}, 1);
    check("t3_rdata_keep", crdata, 32'hCAFE_F00D);
    check("t3_buserr", {31'd0, bus_err}, 0);
    req = 0; bvalid = 0; wen = 0;
    tick();
    check("t3_dok_off", {31'd0, dok}, 0);

    // 4: back-to-back reads, request held into next IDLE
    base = ar_hs;
    req = 1; addr = 32'hA000_0040;
    arready = 1; rvalid = 1; rlast = 1; rdata = 32'h1111_1111;
    tick();
    check("t4_araddr1", araddr, 32'h0000_0040);
    tick();
    tick();
    check("t4_dok1", {31'd0, dok}, 1);
    check("t4_rdata1", crdata, 32'h1111_1111);
    addr = 32'h8000_0080; rdata = 32'h2222_2222;
    tick();
    check("t4_idle_dok", {31'd0, dok}, 0);
    check("t4_idle_ar", {31'd0, arvalid}, 0);
    tick();
    check("t4_arvalid2", {31'd0, arvalid}, 1);
    check("t4_araddr2", araddr, 32'h0000_0080);
    tick();
    tick();
    check("t4_dok2", {31'd0, dok}, 1);
    check("t4_rdata2", crdata, 32'h2222_2222);
    check("t4_arhs", ar_hs - base, 2);
    req = 0; arready = 0; rvalid = 0; rlast = 0;
    tick();

    // 5: SLVERR on write sets sticky bus_err
    base = aw_hs;
    req = 1; wen = 4'hF; addr = 32'h0000_0100; cwdata = 32'hAABB_CCDD;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b10;
    tick();
    tick();
    check("t5_bready", {31'd0, bready}, 1);
    check("t5_vdrop", {30'd0, awvalid, wvalid}, 0);
    tick();
    check("t5_dok", {31'd0, dok}, 1);
    check("t5_buserr", {31'd0, bus_err}, 1);
    check("t5_awhs", aw_hs - base, 1);
    req = 0; wen = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    tick();
    req = 1; addr = 32'h0000_0200;
    arready = 1; rvalid = 1; rlast = 1; rresp = 0; rdata = 32'h3333_3333;
    tick();
    tick();
    tick();
    check("t5_rd_dok", {31'd0, dok}, 1);
    check("t5_rd_rdata", crdata, 32'h3333_3333);
    check("t5_sticky", {31'd0, bus_err}, 1);
    req = 0; arready = 0; rvalid = 0; rlast = 0;
    tick();

    // 6: reset while waiting for rvalid
    req = 1; addr = 32'h8000_0300; arready = 1;
    tick();
    tick();
    arready = 0;
    check("t6_rready", {31'd0, rready}, 1);
    reset = 1;
    #1;
    check("t6_rst_rready", {31'd0, rready}, 0);
    check("t6_rst_dok", {31'd0, dok}, 0);
    check("t6_rst_buserr", {31'd0, bus_err}, 0);
    req = 0;
    tick();
    reset = 0;
    tick();
    check("t6_idle_rready", {31'd0, rready}, 0);
    check("t6_idle_arvalid", {31'd0, arvalid}, 0);
    req = 1; addr = 32'h0000_0400;
    tick();
    check("t6_arvalid", {31'd0, arvalid}, 1);
    check("t6_araddr", araddr, 32'h0000_0400);
    check("t6_noaw", {31'd0, awvalid}, 0);
    arready = 1; rvalid = 1; rlast = 1; rdata = 32'h4444_4444;
    tick();
    tick();
    check("t6_dok", {31'd0, dok}, 1);
    check("t6_rdata", crdata, 32'h4444_4444);
    req = 0; arready = 0; rvalid = 0; rlast = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/dcache_axi_responder.md
Name: dcache_axi_responder

Overview:
- Responder on the data-cache side of the arbiter interface (data_cache_req/wen/addr/wdata/rdata/dok).
- Accepts single-word read or write requests from the write-through data cache and performs them as single-beat AXI3 transactions.
- Returns read data with a one-cycle data_cache_dok completion pulse.
- Sits between the data cache and the top-level AXI crossbar; one transaction outstanding at a time.

Parameters:
AXI_ID, 4'd1, constant ID driven on arid/awid/wid.
ADDR_MAP, 1, 1 = map kseg0/kseg1 (addr[31:29] == 3'b100 or 3'b101) to physical by clearing addr[31:29]; 0 = pass the address through unchanged.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high reset.
data_cache_req  in  1  request from the data cache; level held until data_cache_dok.
data_cache_wen  in  4  byte enables; 0 = read, nonzero = write.
data_cache_addr  in  32  virtual byte address.
data_cache_wdata  in  32  write data.
data_cache_rdata  out  32  read data; valid in the data_cache_dok cycle.
data_cache_dok  out  1  one-cycle completion pulse.
arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/4/3/2/1  AXI read address channel.
arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI read data channel.
rready  out  1
awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/4/3/2/1  AXI write address channel.
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1  AXI write data channel.
wready  in  1
bid/bresp/bvalid  in  4/2/1  AXI write response channel.
bready  out  1
bus_err  out  1  sticky; set on any rresp/bresp != 2'b00; cleared only by reset.

Behaviour:
- Reset (async, while high):
  - FSM goes to IDLE.
  - All valid/ready outputs, data_cache_dok and bus_err are 0.
  - data_cache_rdata and the captured request registers are 0.
  - A transaction in progress at reset is abandoned; there is no replay.
- FSM states: IDLE, AR, R, AWW, B, DONE.
- IDLE:
  - If data_cache_req=1, register addr (mapped per ADDR_MAP, with [1:0] forced to 0), wen and wdata.
  - Next state is AWW if wen!=0, else AR.
  - If data_cache_req=0, stay in IDLE.
- AR:
  - arvalid=1 from a registered output; the request is stable until the handshake.
  - On arvalid&arready go to R.
- R:
  - rready=1.
  - On rvalid&rlast: latch rdata into data_cache_rdata, OR (rresp!=0) into bus_err, go to DONE.
  - rvalid without rlast is ignored (arlen=0, so this never occurs legally).
- AWW:
  - awvalid and wvalid are both asserted on entry.
  - Each is dropped independently after its own handshake (awvalid&awready, wvalid&wready).
  - Either order is legal, including both in the same cycle.
  - Go to B in the cycle after both handshakes have completed; if both complete in the entry cycle, next state is B.
- B:
  - bready=1.
  - On bvalid: OR (bresp!=0) into bus_err, go to DONE.
- DONE:
  - data_cache_dok=1 for exactly this cycle; data_cache_rdata holds the latched value (unchanged on writes).
  - Next state is IDLE unconditionally.
  - The requestor must deassert or change its request in the cycle after dok.
  - A request present in the following IDLE cycle is treated as new.
- Fixed AXI fields:
  - arlen/awlen=0, arsize/awsize=3'b010, arburst/awburst=2'b01.
  - wlast=1 whenever wvalid=1.
  - wstrb = captured wen; ids = AXI_ID.
- Request inputs are sampled only in IDLE; changes mid-transaction are ignored.
- Minimum latency from req seen in IDLE to dok is 3 cycles for both reads and writes (zero-wait slave).
- No AXI valid is ever deasserted before its handshake.

Test Plan:
1. Read, zero-wait slave: req=1, wen=0, addr=0x8000_1004, rdata=0xDEAD_BEEF → araddr=0x0000_1004, arvalid in cycle 1, dok=1 in cycle 3 with data_cache_rdata=0xDEAD_BEEF, bus_err=0.
2. Read with waits: arready delayed 2 cycles, rvalid delayed 3 cycles → arvalid held stable for 3 cycles, dok 7 cycles after req, exactly one AR handshake.
3. Write, split handshakes: wen=4'b0011, addr=0xBFC0_0008, wdata=0x1234_5678; awready in cycle 1, wready in cycle 3 → awaddr=0x1FC0_0008, wstrb=4'b0011, wlast=1, awvalid dropped after cycle 1, bready from cycle 4, dok one cycle after bvalid.
4. Back-to-back: read completes, then req held with a new addr in the next IDLE → second AR issued; no duplicate transaction for the first address.
5. Error response: bresp=2'b10 on a write → dok still pulses and bus_err=1, persisting through a subsequent OKAY read until reset.
6. Reset mid-R: assert reset while awaiting rvalid → rready=0 and dok=0 immediately, FSM in IDLE after release, a new req starts cleanly with AR.
